// File: rtl/synth_const_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_const_pkg
//  Description : Shared constants for the oscillator constant-map builder:
//                semitone base table, word widths, tuning unity, note count,
//                reference octave and the builder FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package synth_const_pkg;

  localparam int CONST_W     = 24;     // phase-increment word width
  localparam int TUNE_W      = 16;     // tune word width, unsigned Q2.14
  localparam int TUNE_FRAC   = 14;     // fractional bits of the tune word
  localparam int TUNE_UNITY  = 16384;  // 1.0 in Q2.14
  localparam int NOTE_COUNT  = 256;    // table entries
  localparam int TOP_REF_OCT = 10;     // octave at which BASE is used unshifted
  localparam int SEMI_COUNT  = 12;
  localparam int MAX_OCT     = 21;     // octave of note 255
  localparam int BASE_W      = 13;

  // Phase increments of one reference octave, semitone 0..11
  localparam logic [BASE_W-1:0] BASE [SEMI_COUNT] = '{
    13'd2608, 13'd2763, 13'd2927, 13'd3101, 13'd3286, 13'd3481,
    13'd3688, 13'd3908, 13'd4140, 13'd4386, 13'd4647, 13'd4923
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Base constant for a semitone; codes 12..15 never occur and map to 0
  function automatic logic [BASE_W-1:0] base_of(input logic [3:0] i_semi);
    logic [BASE_W-1:0] w_b;
    w_b = '0;
    case (i_semi)
      4'd0:    w_b = BASE[0];
      4'd1:    w_b = BASE[1];
      4'd2:    w_b = BASE[2];
      4'd3:    w_b = BASE[3];
      4'd4:    w_b = BASE[4];
      4'd5:    w_b = BASE[5];
      4'd6:    w_b = BASE[6];
      4'd7:    w_b = BASE[7];
      4'd8:    w_b = BASE[8];
      4'd9:    w_b = BASE[9];
      4'd10:   w_b = BASE[10];
      4'd11:   w_b = BASE[11];
      default: w_b = '0;
    endcase
    return w_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/const_calc.sv
`default_nettype none
// ============================================================================
//  Module      : const_calc
//  Description : Two-stage datapath producing one table word per cycle.
//                Stage A: BASE[semi] * tune, rescaled by the Q2.14 fraction.
//                Stage B: octave shift relative to the reference octave,
//                saturated to CONST_W bits, registered onto o_data.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                i_semi       - semitone 0..11
//                i_oct        - octave 0..21
//                i_tune       - latched tune word (Q2.14)
//                o_data       - phase increment, two cycles after inputs
//  Revision    : 1.0  initial release
// ============================================================================
module const_calc
  import synth_const_pkg::*;
#(
  parameter int CONST_W = synth_const_pkg::CONST_W,
  parameter int TUNE_W  = synth_const_pkg::TUNE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         i_semi,
  input  logic [4:0]         i_oct,
  input  logic [TUNE_W-1:0]  i_tune,
  output logic [CONST_W-1:0] o_data
);

  localparam int         c_PROD_W  = BASE_W + TUNE_W;
  localparam int         c_V_W     = c_PROD_W - TUNE_FRAC;
  // Widest left shift is MAX_OCT - TOP_REF_OCT, so this never loses bits
  localparam int         c_SH_W    = c_V_W + (MAX_OCT - TOP_REF_OCT);
  localparam logic [4:0] c_REF_OCT = 5'(TOP_REF_OCT);

  logic [c_V_W-1:0]   r_v;
  logic [4:0]         r_oct;
  logic [CONST_W-1:0] r_data;
  logic [c_SH_W-1:0]  w_ext;
  logic [c_SH_W-1:0]  w_sh;
  logic [CONST_W-1:0] w_sat;

  assign w_ext = c_SH_W'(r_v);

  always_comb begin
    w_sh = '0;
    if (r_oct < c_REF_OCT) begin
      w_sh = w_ext >> (c_REF_OCT - r_oct);
    end else begin
      w_sh = w_ext << (r_oct - c_REF_OCT);
    end
  end

  generate
    if (c_SH_W > CONST_W) begin : g_sat
      assign w_sat = (|w_sh[c_SH_W-1:CONST_W]) ? {CONST_W{1'b1}} : w_sh[CONST_W-1:0];
    end else begin : g_nosat
      assign w_sat = CONST_W'(w_sh);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v    <= '0;
      r_oct  <= '0;
      r_data <= '0;
    end else begin
      // Truncating rescale: drop the Q2.14 fraction of the product
      r_v    <= c_V_W'((c_PROD_W'(base_of(i_semi)) * c_PROD_W'(i_tune)) >> TUNE_FRAC);
      r_oct  <= i_oct;
      r_data <= w_sat;
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/constmap_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : constmap_table_writer
//  Description : Builds the 256-entry note -> phase-increment table. Each run
//                walks notes 0..255 (semitone/octave wrap counters), computes
//                BASE[s]*tune octave-shifted and saturated, and writes it to
//                the table RAM write port. Three-stage pipeline: index,
//                multiply, shift/saturate onto wr_*.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                i_start       - 1-cycle rebuild request (ignored while busy)
//                i_tune        - tuning factor Q2.14, sampled on acceptance
//                o_busy        - run in progress
//                o_done        - 1-cycle pulse after the last write
//                o_wr_en       - table RAM write enable
//                o_wr_addr     - table RAM write address (note number)
//                o_wr_data     - table RAM write data
//  Revision    : 1.0  initial release
// ============================================================================
module constmap_table_writer
  import synth_const_pkg::*;
#(
  parameter bit AUTO_INIT = 1'b1,
  parameter int CONST_W   = synth_const_pkg::CONST_W,
  parameter int TUNE_W    = synth_const_pkg::TUNE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [TUNE_W-1:0]  i_tune,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_wr_en,
  output logic [7:0]         o_wr_addr,
  output logic [CONST_W-1:0] o_wr_data
);

  localparam logic [7:0] c_LAST_NOTE = 8'(NOTE_COUNT - 1);

  state_t            r_state;
  logic              r_auto_pend;
  logic              r_busy;
  logic              r_done;
  logic [TUNE_W-1:0] r_tune;
  logic [3:0]        r_semi;
  logic [4:0]        r_oct;
  logic [7:0]        r_note;
  // stage 1: index registers
  logic              r_s1_vld;
  logic [3:0]        r_s1_semi;
  logic [4:0]        r_s1_oct;
  logic [7:0]        r_s1_addr;
  // stage 2: address riding alongside the multiply
  logic              r_s2_vld;
  logic [7:0]        r_s2_addr;
  // stage 3: write-port control
  logic              r_wr_en;
  logic [7:0]        r_wr_addr;
  logic              w_accept;

  // A run cannot start on the cycle done is high, i.e. the cycle busy falls
  assign w_accept = (r_state == ST_IDLE) && !r_done && (i_start || r_auto_pend);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_auto_pend <= AUTO_INIT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tune      <= TUNE_W'(TUNE_UNITY);
      r_semi      <= '0;
      r_oct       <= '0;
      r_note      <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_semi   <= '0;
      r_s1_oct    <= '0;
      r_s1_addr   <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_s1_vld <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_auto_pend <= 1'b0;
            r_tune      <= i_tune;
            r_semi      <= '0;
            r_oct       <= '0;
            r_note      <= '0;
          end
        end
        ST_RUN: begin
          r_s1_vld  <= 1'b1;
          r_s1_semi <= r_semi;
          r_s1_oct  <= r_oct;
          r_s1_addr <= r_note;
          if (r_semi == 4'd11) begin
            r_semi <= '0;
            r_oct  <= r_oct + 5'd1;
          end else begin
            r_semi <= r_semi + 4'd1;
          end
          r_note <= r_note + 8'd1;
          if (r_note == c_LAST_NOTE) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last entry is on the write port this cycle: pipeline is empty next
          if (r_wr_en && (r_wr_addr == c_LAST_NOTE)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      r_s2_vld  <= r_s1_vld;
      r_s2_addr <= r_s1_addr;
      r_wr_en   <= r_s2_vld;
      if (r_s2_vld) begin
        r_wr_addr <= r_s2_addr;
      end
    end
  end

  const_calc #(
    .CONST_W (CONST_W),
    .TUNE_W  (TUNE_W)
  ) u_calc (
    .clk    (clk),
    .reset  (reset),
    .i_semi (r_s1_semi),
    .i_oct  (r_s1_oct),
    .i_tune (r_tune),
    .o_data (o_wr_data)
  );

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_constmap_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_constmap_table_writer
//  Description : Scoreboard bench for constmap_table_writer. Each accepted run
//                pushes 256 expected writes computed from the note law; the
//                write-port monitor pops and compares them. Run-level timing
//                (first write, done, busy) and reference values are checked.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_constmap_table_writer;

  localparam int CW = 24;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [TW-1:0] i_tune;
  logic          o_busy;
  logic          o_done;
  logic          o_wr_en;
  logic [7:0]    o_wr_addr;
  logic [CW-1:0] o_wr_data;

  always #5 clk = ~clk;

  constmap_table_writer #(
    .AUTO_INIT (1'b1),
    .CONST_W   (CW),
    .TUNE_W    (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_tune    (i_tune),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data)
  );

  typedef struct packed {
    logic [7:0]    addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  wr_t           mon_e;
  logic [CW-1:0] cap [256];
  int            n_vec  = 0;
  int            n_miss = 0;
  int            base_t [12] = '{2608, 2763, 2927, 3101, 3286, 3481,
                                 3688, 3908, 4140, 4386, 4647, 4923};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Note law: n = 12*o + s, v = BASE[s]*tune >> 14, octave shift, saturate
  function automatic logic [CW-1:0] model(input int n, input int tune);
    longint v;
    longint r;
    int     s;
    int     o;
    s = n % 12;
    o = n / 12;
    v = (longint'(base_t[s]) * longint'(tune)) >> 14;
    if (o < 10) r = v >> (10 - o);
    else        r = v << (o - 10);
    if (r > 64'd16777215) r = 64'd16777215;
    return r[CW-1:0];
  endfunction

  // Write-port monitor: pops the scoreboard on every write
  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("wr_unexpected_addr", {56'd0, o_wr_addr}, 64'd256);
      end else begin
        mon_e = sb.pop_front();
        check_val("wr_addr", {56'd0, o_wr_addr}, {56'd0, mon_e.addr});
        check_val("wr_data", {40'd0, o_wr_data}, {40'd0, mon_e.data});
        cap[o_wr_addr] = o_wr_data;
      end
    end
  end

  task automatic pulse_start(input logic [TW-1:0] t);
    @(negedge clk);
    i_tune  = t;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge just after the accepting edge (k = 0)
  task automatic run_build(input int tune_lat, input bit mid_start,
                           input bit chg_tune, input int abort_at);
    int         my_wr      = 0;
    int         my_done    = 0;
    int         first_k    = -1;
    int         done_k     = -1;
    int         abort_k    = -1;
    logic [7:0] first_addr = 8'hxx;
    wr_t        e;
    for (int n = 0; n < 256; n++) begin
      e.addr = 8'(n);
      e.data = model(n, tune_lat);
      sb.push_back(e);
    end
    check_val("busy_on_accept", {63'd0, o_busy}, 64'd1);
    for (int k = 0; k <= 300; k++) begin
      if (k > 0) @(negedge clk);
      i_start = (mid_start && (k == 5 || k == 100 || k == 259)) ? 1'b1 : 1'b0;
      if (chg_tune && k == 50) i_tune = 16'd8192;
      if (o_wr_en === 1'b1) begin
        if (first_k < 0) begin
          first_k    = k;
          first_addr = o_wr_addr;
        end
        my_wr++;
      end
      if (o_done === 1'b1) begin
        my_done++;
        if (done_k < 0) done_k = k;
        check_val("busy_at_done", {63'd0, o_busy}, 64'd0);
      end
      if (k == 258 && abort_k < 0) check_val("busy_before_done", {63'd0, o_busy}, 64'd1);
      if (mid_start && k == 260) check_val("start_at_fall_ignored", {63'd0, o_busy}, 64'd0);
      if (abort_at > 0) begin
        if (abort_k < 0 && my_wr == abort_at) begin
          reset   = 1'b1;
          abort_k = k;
        end else if (abort_k >= 0 && k == abort_k + 1) begin
          check_val("abort_wr_en", {63'd0, o_wr_en}, 64'd0);
          check_val("abort_busy",  {63'd0, o_busy},  64'd0);
          check_val("abort_done",  {63'd0, o_done},  64'd0);
        end else if (abort_k >= 0 && k == abort_k + 4) begin
          break;
        end
      end
    end
    if (abort_at > 0) begin
      check_val("abort_reached", {63'd0, (abort_k >= 0)}, 64'd1);
      check_val("abort_wr_count", 64'(my_wr), 64'(abort_at));
      check_val("abort_no_done", 64'(my_done), 64'd0);
      sb.delete();
    end else begin
      check_val("first_wr_latency", 64'(first_k), 64'd3);
      check_val("first_wr_addr", {56'd0, first_addr}, 64'd0);
      check_val("done_latency", 64'(done_k), 64'd259);
      check_val("write_count", 64'(my_wr), 64'd256);
      check_val("done_count", 64'(my_done), 64'd1);
      check_val("sb_drained", 64'(sb.size()), 64'd0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_start = 1'b0;
    i_tune  = 16'd16384;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_val("rst_busy",    {63'd0, o_busy},    64'd0);
    check_val("rst_done",    {63'd0, o_done},    64'd0);
    check_val("rst_wr_en",   {63'd0, o_wr_en},   64'd0);
    check_val("rst_wr_addr", {56'd0, o_wr_addr}, 64'd0);
    check_val("rst_wr_data", {40'd0, o_wr_data}, 64'd0);

    // automatic build after reset release
    release_reset();
    run_build(16384, 1'b0, 1'b0, 0);
    check_val("t1_addr0",   {40'd0, cap[0]},   64'd2);
    check_val("t1_addr69",  {40'd0, cap[69]},  64'd137);
    check_val("t1_addr129", {40'd0, cap[129]}, 64'd4386);
    check_val("t1_addr255", {40'd0, cap[255]}, 64'd6350848);

    // maximum tune, top octave saturates
    pulse_start(16'd65535);
    run_build(65535, 1'b0, 1'b0, 0);
    check_val("t2_addr0",   {40'd0, cap[0]},   64'd10);
    check_val("t2_addr255", {40'd0, cap[255]}, 64'hFFFFFF);

    // start pulses mid-run and on the falling-busy cycle are ignored
    pulse_start(16'd16384);
    run_build(16384, 1'b1, 1'b0, 0);

    // tune change mid-run is not seen until the next run
    pulse_start(16'd16384);
    run_build(16384, 1'b0, 1'b1, 0);
    check_val("t4_addr129_run1", {40'd0, cap[129]}, 64'd4386);
    pulse_start(16'd8192);
    run_build(8192, 1'b0, 1'b0, 0);
    check_val("t4_addr129_run2", {40'd0, cap[129]}, 64'd2193);

    // reset at write 40 aborts; the post-reset run is complete from addr 0
    pulse_start(16'd16384);
    run_build(16384, 1'b0, 1'b0, 40);
    release_reset();
    run_build(16384, 1'b0, 1'b0, 0);

    // zero tune writes zeros everywhere
    pulse_start(16'd0);
    run_build(0, 1'b0, 1'b0, 0);
    check_val("t6_addr0",   {40'd0, cap[0]},   64'd0);
    check_val("t6_addr255", {40'd0, cap[255]}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
